// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the dual-slot hazard/issue controller:
// state encoding, default register-address width and issue_mask layout.
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 3;

  typedef logic [2:0] state_t;

  // Controller states; kept as plain constants so the debug port value is stable.
  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_LDSTALL = 3'd1;
  localparam logic [2:0] ST_SPLIT   = 3'd2;
  localparam logic [2:0] ST_MULWAIT = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;

  // issue_mask bit positions and the common patterns built from them.
  localparam int ISSUE_SLOT1 = 0;
  localparam int ISSUE_SLOT2 = 1;

  localparam logic [1:0] ISSUE_NONE = 2'b00;
  localparam logic [1:0] ISSUE_S1   = 2'b01;
  localparam logic [1:0] ISSUE_S2   = 2'b10;
  localparam logic [1:0] ISSUE_BOTH = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of decode-slot, EX-feedback and pipeline-control signals exchanged
// between the front end (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);

  logic              id1_valid;
  logic [REG_AW-1:0] id1_srca;
  logic [REG_AW-1:0] id1_srcb;
  logic [REG_AW-1:0] id1_dst;
  logic              id1_we;
  logic              id1_mul;

  logic              id2_valid;
  logic [REG_AW-1:0] id2_srca;
  logic [REG_AW-1:0] id2_srcb;
  logic [REG_AW-1:0] id2_dst;
  logic              id2_we;
  logic              id2_mul;

  logic              ex_load_valid;
  logic [REG_AW-1:0] ex_load_dst;
  logic              ex_branch_taken;
  logic              mul_done;

  logic              stall;
  logic              flush;
  logic              pc_hold;
  logic              idex_bubble;
  logic [1:0]        issue_mask;
  logic              mul_start;
  logic              mul_timeout;
  logic [2:0]        ctrl_state;

  modport master (
    output id1_valid, id1_srca, id1_srcb, id1_dst, id1_we, id1_mul,
    output id2_valid, id2_srca, id2_srcb, id2_dst, id2_we, id2_mul,
    output ex_load_valid, ex_load_dst, ex_branch_taken, mul_done,
    input  stall, flush, pc_hold, idex_bubble, issue_mask,
    input  mul_start, mul_timeout, ctrl_state
  );

  modport slave (
    input  id1_valid, id1_srca, id1_srcb, id1_dst, id1_we, id1_mul,
    input  id2_valid, id2_srca, id2_srcb, id2_dst, id2_we, id2_mul,
    input  ex_load_valid, ex_load_dst, ex_branch_taken, mul_done,
    output stall, flush, pc_hold, idex_bubble, issue_mask,
    output mul_start, mul_timeout, ctrl_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Purely combinational register comparators: load-use hazard against the
// load in EX, and the intra-pair dependency of slot2 on slot1's result.
// Register 0 gets no special treatment.
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id1_valid,
  input  logic [REG_AW-1:0] id1_srca,
  input  logic [REG_AW-1:0] id1_srcb,
  input  logic [REG_AW-1:0] id1_dst,
  input  logic              id1_we,
  input  logic              id2_valid,
  input  logic [REG_AW-1:0] id2_srca,
  input  logic [REG_AW-1:0] id2_srcb,
  input  logic [REG_AW-1:0] id2_dst,
  input  logic              id2_we,
  input  logic              ex_load_valid,
  input  logic [REG_AW-1:0] ex_load_dst,
  output logic              loaduse,
  output logic              pairdep
);

  logic [1:0]        slot_valid;
  logic [REG_AW-1:0] slot_srca [2];
  logic [REG_AW-1:0] slot_srcb [2];
  logic [1:0]        slot_hit;

  assign slot_valid   = {id2_valid, id1_valid};
  assign slot_srca[0] = id1_srca;
  assign slot_srca[1] = id2_srca;
  assign slot_srcb[0] = id1_srcb;
  assign slot_srcb[1] = id2_srcb;

  // A valid slot reading the register the EX load is about to write must wait.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_hit[gi] = slot_valid[gi] &&
                            ((ex_load_dst == slot_srca[gi]) || (ex_load_dst == slot_srcb[gi]));
    end
  endgenerate

  assign loaduse = ex_load_valid && (|slot_hit);

  // Slot2 reads slot1's result (RAW) or overwrites it (WAW): the pair cannot go together.
  assign pairdep = id1_valid && id2_valid && id1_we &&
                   ((id1_dst == id2_srca) || (id1_dst == id2_srcb) ||
                    (id2_we && (id1_dst == id2_dst)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and issue controller for the dual-slot front end. Sequences
// load-use stalls, pair splits, multiplier waits and branch flushes, and
// decides per cycle which decoded slots issue.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int FLUSH_CYC   = 1,
  parameter int MUL_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  // Counter reload for extra flush cycles, and the last allowed MULWAIT count.
  localparam logic [7:0] FLUSH_RELOAD = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MUL_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic       pend2_reg, pend2_next;
  logic       timeout_reg, timeout_next;

  logic       loaduse, pairdep;
  logic       take_branch;
  logic       stall_c, flush_c, hold_c, bubble_c, mul_start_c;
  logic [1:0] mask_c;

  pipe_hazard_ctrl_hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .id1_valid     (bus.id1_valid),
    .id1_srca      (bus.id1_srca),
    .id1_srcb      (bus.id1_srcb),
    .id1_dst       (bus.id1_dst),
    .id1_we        (bus.id1_we),
    .id2_valid     (bus.id2_valid),
    .id2_srca      (bus.id2_srca),
    .id2_srcb      (bus.id2_srcb),
    .id2_dst       (bus.id2_dst),
    .id2_we        (bus.id2_we),
    .ex_load_valid (bus.ex_load_valid),
    .ex_load_dst   (bus.ex_load_dst),
    .loaduse       (loaduse),
    .pairdep       (pairdep)
  );

  // Next-state and per-cycle control decisions from the current state and ID/EX inputs.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pend2_next   = pend2_reg;
    timeout_next = timeout_reg;
    stall_c      = 1'b0;
    flush_c      = 1'b0;
    hold_c       = 1'b0;
    bubble_c     = 1'b0;
    mul_start_c  = 1'b0;
    mask_c       = ISSUE_NONE;
    mask_c[ISSUE_SLOT1] = bus.id1_valid;
    mask_c[ISSUE_SLOT2] = bus.id2_valid;
    take_branch  = 1'b0;

    case (state_reg)
      ST_RUN, ST_LDSTALL: begin
        // LDSTALL is RUN with the branch and load-use checks suppressed for one cycle.
        if ((state_reg == ST_RUN) && bus.ex_branch_taken) begin
          take_branch = 1'b1;
        end else if ((state_reg == ST_RUN) && loaduse) begin
          stall_c    = 1'b1;
          hold_c     = 1'b1;
          bubble_c   = 1'b1;
          mask_c     = ISSUE_NONE;
          state_next = ST_LDSTALL;
        end else if (bus.id1_valid && bus.id1_mul) begin
          // Slot1 multiply goes alone; a valid slot2 is remembered for a later SPLIT.
          mul_start_c = 1'b1;
          mask_c      = ISSUE_S1;
          pend2_next  = bus.id2_valid;
          stall_c     = 1'b1;
          hold_c      = 1'b1;
          count_next  = 8'd0;
          state_next  = ST_MULWAIT;
        end else if (pairdep) begin
          mask_c     = ISSUE_S1;
          stall_c    = 1'b1;
          hold_c     = 1'b1;
          state_next = ST_SPLIT;
        end else if (bus.id2_valid && bus.id2_mul) begin
          mask_c      = ISSUE_BOTH;
          mul_start_c = 1'b1;
          stall_c     = 1'b1;
          hold_c      = 1'b1;
          pend2_next  = 1'b0;
          count_next  = 8'd0;
          state_next  = ST_MULWAIT;
        end else begin
          state_next = ST_RUN;
        end
      end

      ST_SPLIT: begin
        // Second half of a split pair; a taken branch drops slot2 entirely.
        if (bus.ex_branch_taken) begin
          take_branch = 1'b1;
        end else begin
          mask_c     = bus.id2_valid ? ISSUE_S2 : ISSUE_NONE;
          state_next = ST_RUN;
          if (bus.id2_valid && bus.id2_mul) begin
            mul_start_c = 1'b1;
            stall_c     = 1'b1;
            hold_c      = 1'b1;
            pend2_next  = 1'b0;
            count_next  = 8'd0;
            state_next  = ST_MULWAIT;
          end
        end
      end

      ST_MULWAIT: begin
        // Multiplier owns EX: branches are ignored, exit on done or on timeout.
        stall_c    = 1'b1;
        hold_c     = 1'b1;
        bubble_c   = 1'b1;
        mask_c     = ISSUE_NONE;
        count_next = count_reg + 8'd1;
        if (bus.mul_done || (count_reg == TIMEOUT_LAST)) begin
          if (!bus.mul_done) begin
            timeout_next = 1'b1;
          end
          state_next = pend2_reg ? ST_SPLIT : ST_RUN;
          pend2_next = 1'b0;
        end
      end

      ST_FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        mask_c   = ISSUE_NONE;
        if (bus.ex_branch_taken) begin
          take_branch = 1'b1;
        end else begin
          count_next = count_reg - 8'd1;
          if (count_reg <= 8'd1) begin
            state_next = ST_RUN;
          end
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase

    // A taken branch wins over anything chosen above in the states that honour it.
    if (take_branch) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      stall_c  = 1'b0;
      hold_c   = 1'b0;
      mask_c   = ISSUE_NONE;
      if (FLUSH_CYC > 1) begin
        state_next = ST_FLUSH;
        count_next = FLUSH_RELOAD;
      end else begin
        state_next = ST_RUN;
      end
    end
  end

  // Controller state registers; reset drops straight back to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      count_reg   <= 8'd0;
      pend2_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pend2_reg   <= pend2_next;
      timeout_reg <= timeout_next;
    end
  end

  // Outputs are held at 0 while reset is asserted, so nothing leaks mid-reset.
  assign bus.stall       = reset & stall_c;
  assign bus.flush       = reset & flush_c;
  assign bus.pc_hold     = reset & hold_c;
  assign bus.idex_bubble = reset & bubble_c;
  assign bus.mul_start   = reset & mul_start_c;
  assign bus.mul_timeout = reset & timeout_reg;
  assign bus.issue_mask  = reset ? mask_c : ISSUE_NONE;
  assign bus.ctrl_state  = reset ? state_reg : ST_RUN;

endmodule
